pll_drp_reconfig: RTL and testbench

- Runtime reconfiguration controller for a PLLE4/MMCME4-class primitive in the CRG: takes new feedback-multiply and per-output divide values and applies them over the DRP port.
- Sequence per request: hold PLL in reset, read-modify-write each counter register pair, release reset, wait for lock.
- Sits beside the PLL wrapper and drives its DADDR/DEN/DWE/DI/RST. Reads DO/DRDY/LOCKED back.
- NUM_OUT generalises the channel count, so one controller serves both 2-output PLLs and 7-output MMCMs.

---
 rtl/pll_drp_reconfig.sv | 177 +++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_reconfig.sv
// DRP reconfiguration controller for a PLLE4/MMCME4-class primitive.
// Holds the PLL in reset, read-modify-writes the CLKFBOUT and CLKOUTi counter pairs, then waits for lock.
module pll_drp_reconfig #(
    parameter int         NUM_OUT      = 2,
    parameter logic [6:0] ADDR_OUT0    = 7'h08,
    parameter logic [6:0] ADDR_FB      = 7'h0C,
    parameter int         DRDY_TIMEOUT = 64,
    parameter int         LOCK_TIMEOUT = 65536
) (
    input  logic                 clk_in0,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [6:0]           cfg_mult,
    input  logic [7*NUM_OUT-1:0] cfg_div,
    output logic [6:0]           daddr,
    output logic                 den,
    output logic                 dwe,
    output logic [15:0]          di,
    input  logic [15:0]          do_in,
    input  logic                 drdy,
    input  logic                 locked,
    output logic                 pll_rst,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err
);

    localparam int NUM_REG = 2 * (NUM_OUT + 1);
    localparam int IDX_W   = $clog2(NUM_REG);
    localparam int PAIR_W  = IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REG - 1);

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
        S_RST_OFF, S_LOCK_WAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'd0,
        ERR_CFG  = 2'd1,
        ERR_DRDY = 2'd2,
        ERR_LOCK = 2'd3
    } err_t;

    state_t            state, state_next;
    err_t              err_q, err_pend;
    logic [6:0]        vals [NUM_OUT+1];   // entry 0 is the feedback multiply
    logic [IDX_W-1:0]  reg_idx;
    logic [PAIR_W-1:0] pair;
    logic [15:0]       rd_data;
    logic [31:0]       tmo_cnt;
    logic              lock_prev;

    logic              accept, cfg_legal, last_reg, drdy_tmo, lock_tmo, lock_ok;
    logic [6:0]        reg_addr, d;
    logic [5:0]        d_high, d_low;
    logic [15:0]       reg1, reg2, wr_data;

    assign accept   = cfg_valid && (state == S_IDLE);
    assign last_reg = (reg_idx == LAST_IDX);
    assign drdy_tmo = (tmo_cnt == 32'(DRDY_TIMEOUT - 1));
    assign lock_tmo = (tmo_cnt == 32'(LOCK_TIMEOUT - 1));
    assign lock_ok  = locked && lock_prev;
    assign pair     = reg_idx[IDX_W-1:1];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cfg_legal = (cfg_mult != 7'd0) && (cfg_mult <= 7'd64);
        for (int i = 0; i < NUM_OUT; i++) begin
            if (cfg_div[7*i +: 7] == 7'd0 || cfg_div[7*i +: 7] > 7'd64)
                cfg_legal = 1'b0;
        end
    end

    // Word being written: divide D split into high = D>>1 and low = D-high; D=64 wraps both fields to 0.
    always_comb begin
        d        = vals[pair];
        d_high   = d[6:1];
        d_low    = 6'(d - {1'b0, d_high});
        reg_addr = (reg_idx < IDX_W'(2)) ? ADDR_FB + 7'(reg_idx)
                                         : ADDR_OUT0 + 7'(reg_idx) - 7'd2;
        reg1     = (rd_data & 16'hF000) |
                   ((d == 7'd64) ? 16'h0000 : {4'b0, d_high, d_low});
        reg2     = (rd_data & 16'hFF3F) | {8'b0, d[0], (d == 7'd1), 6'b0};
        wr_data  = reg_idx[0] ? reg2 : reg1;
    end

    always_ff @(posedge clk_in0) begin
        if (reset) state <= S_RESET;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RESET:     state_next = S_IDLE;
            S_IDLE:      if (accept) state_next = cfg_legal ? S_RST_ON : S_DONE;
            S_RST_ON:    state_next = S_RD;
            S_RD:        state_next = S_RD_WAIT;
            S_RD_WAIT:   if (drdy) state_next = S_WR;
                         else if (drdy_tmo) state_next = S_RST_OFF;
            S_WR:        state_next = S_WR_WAIT;
            S_WR_WAIT:   if (drdy) state_next = last_reg ? S_RST_OFF : S_RD;
                         else if (drdy_tmo) state_next = S_RST_OFF;
            S_RST_OFF:   state_next = S_LOCK_WAIT;
            S_LOCK_WAIT: if (lock_ok || lock_tmo) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == S_IDLE);
        busy      = !(state inside {S_RESET, S_IDLE});
        done      = (state == S_DONE);
        den       = (state inside {S_RD, S_WR});
        dwe       = (state == S_WR);
        daddr     = den ? reg_addr : 7'd0;
        di        = (state == S_WR) ? wr_data : 16'd0;
        pll_rst   = (state inside {S_RESET, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT});
    end

    // NOTE: the captured request values have no reset; they are always loaded at accept before use.
    always_ff @(posedge clk_in0) begin
        if (accept) begin
            vals[0] <= cfg_mult;
            for (int i = 0; i < NUM_OUT; i++) vals[i+1] <= cfg_div[7*i +: 7];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_in0) begin
        if (reset) begin
            err_q     <= ERR_OK;
            err_pend  <= ERR_OK;
            reg_idx   <= '0;
            rd_data   <= 16'd0;
            tmo_cnt   <= 32'd0;
            lock_prev <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    err_q    <= cfg_legal ? ERR_OK : ERR_CFG;
                    err_pend <= ERR_OK;
                    reg_idx  <= '0;
                end
                S_RD, S_WR: tmo_cnt <= 32'd0;
                S_RD_WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (drdy) rd_data <= do_in;
                    else if (drdy_tmo) err_pend <= ERR_DRDY;
                end
                S_WR_WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (drdy && !last_reg) reg_idx <= reg_idx + IDX_W'(1);
                    else if (!drdy && drdy_tmo) err_pend <= ERR_DRDY;
                end
                // Lock budget counts from the release cycle itself.
                S_RST_OFF: begin
                    tmo_cnt   <= 32'd1;
                    lock_prev <= 1'b0;
                end
                S_LOCK_WAIT: begin
                    tmo_cnt   <= tmo_cnt + 32'd1;
                    lock_prev <= locked;
                    if (lock_ok)       err_q <= err_pend;
                    else if (lock_tmo) err_q <= (err_pend != ERR_OK) ? err_pend : ERR_LOCK;
                end
                default: ;
            endcase
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Self-checking bench for pll_drp_reconfig: DRP/PLL behavioural model plus a scoreboard of expected DRP accesses.
module tb_pll_drp_reconfig;

    localparam int NUM_OUT = 2;

    logic                 clk_in0, reset, cfg_valid, cfg_ready;
    logic [6:0]           cfg_mult;
    logic [7*NUM_OUT-1:0] cfg_div;
    logic [6:0]           daddr;
    logic                 den, dwe, drdy, locked, pll_rst, busy, done;
    logic [15:0]          di, do_in;
    logic [1:0]           err;

    pll_drp_reconfig #(.NUM_OUT(NUM_OUT), .LOCK_TIMEOUT(100)) dut (
        .clk_in0(clk_in0), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mult(cfg_mult), .cfg_div(cfg_div), .daddr(daddr), .den(den), .dwe(dwe),
        .di(di), .do_in(do_in), .drdy(drdy), .locked(locked), .pll_rst(pll_rst),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic        we;
        logic [15:0] data;
    } acc_t;

    acc_t exp_q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   den_cnt = 0, rd_cnt = 0, wr_cnt = 0, last_den_cyc = 0;
    int   withhold_at = -1, pend = 0, lock_cnt = 0;
    bit   lock_en = 1'b1;

    initial begin
        clk_in0 = 1'b0;
        forever #5 clk_in0 = ~clk_in0;
    end

    initial forever begin
        @(posedge clk_in0);
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // DRP slave answers two cycles after den (unless withheld); PLL locks 10 cycles after RST drops.
    initial begin
        acc_t e;
        drdy = 1'b0; do_in = 16'h0000; locked = 1'b0;
        forever begin
            @(negedge clk_in0);
            drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin drdy = 1'b1; do_in = 16'hF000; end
            end
            if (dwe === 1'b1 && den !== 1'b1) begin
                checks++; errors++;
                $display("FAIL dwe_without_den den=%b dwe=%b required den=1", den, dwe);
            end
            if (den === 1'b1) begin
                den_cnt++; last_den_cyc = cyc;
                if (dwe) wr_cnt++; else rd_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drp_unexpected addr=%h we=%b di=%h required no access", daddr, dwe, di);
                end else begin
                    e = exp_q.pop_front();
                    if (daddr !== e.addr || dwe !== e.we || (e.we && di !== e.data)) begin
                        errors++;
                        $display("FAIL drp_access addr=%h we=%b di=%h required addr=%h we=%b di=%h",
                                 daddr, dwe, di, e.addr, e.we, e.data);
                    end
                end
                checks++;
                if (pll_rst !== 1'b1) begin
                    errors++;
                    $display("FAIL drp_pll_rst pll_rst=%b required 1", pll_rst);
                end
                if (den_cnt != withhold_at) pend = 2;
            end
            if (pll_rst !== 1'b0) begin
                locked = 1'b0; lock_cnt = 0;
            end else if (!locked && lock_en) begin
                lock_cnt++;
                if (lock_cnt >= 10) locked = 1'b1;
            end
        end
    end

    task automatic push_pair(input logic [6:0] a, input logic [15:0] w);
        exp_q.push_back('{addr: a, we: 1'b0, data: 16'h0000});
        exp_q.push_back('{addr: a, we: 1'b1, data: w});
    endtask

    // Starts and ends on a negedge; returns on the negedge right after the accepting edge.
    task automatic send(input logic [6:0] m, input logic [6:0] d0, input logic [6:0] d1);
        int n = 0;
        cfg_mult = m; cfg_div = {d1, d0}; cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && n < 50) begin @(negedge clk_in0); n++; end
        if (cfg_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout cfg_ready=%b required 1", cfg_ready);
        end
        @(negedge clk_in0);
        cfg_valid = 1'b0;
        cfg_mult  = 7'($urandom);
        cfg_div   = (7*NUM_OUT)'($urandom);
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin @(negedge clk_in0); n++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout done=%b required 1 within %0d cycles", done, budget);
        end
        done_cyc = cyc;
    endtask

    task automatic wait_rst_fall(output int fall_cyc);
        int n = 0;
        while (pll_rst !== 1'b0 && n < 300) begin @(negedge clk_in0); n++; end
        checks++;
        if (pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL rst_fall_timeout pll_rst=%b required 0", pll_rst);
        end
        fall_cyc = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_valid = 1'b0; cfg_mult = 7'd0; cfg_div = '0;
        repeat (3) @(negedge clk_in0);
        checks++;
        if ({cfg_ready, den, dwe, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags ready/den/dwe/busy/done=%b required 00000", {cfg_ready, den, dwe, busy, done});
        end
        checks++;
        if (daddr !== 7'd0 || di !== 16'd0 || err !== 2'd0) begin
            errors++;
            $display("FAIL reset_data daddr=%h di=%h err=%0d required 0 0 0", daddr, di, err);
        end
        checks++;
        if (pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_pll_rst pll_rst=%b required 1", pll_rst);
        end
        reset = 1'b0;
        @(negedge clk_in0);
        checks++;
        if (cfg_ready !== 1'b1 || pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_exit cfg_ready=%b pll_rst=%b required 1 0", cfg_ready, pll_rst);
        end
    endtask

    task automatic run_normal(input string name, input logic [6:0] m, input logic [6:0] d0, input logic [6:0] d1,
                              input logic [15:0] w [6]);
        int rd0 = rd_cnt, wr0 = wr_cnt, dc;
        logic [6:0] addrs [6] = '{7'h0C, 7'h0D, 7'h08, 7'h09, 7'h0A, 7'h0B};
        for (int i = 0; i < 6; i++) push_pair(addrs[i], w[i]);
        send(m, d0, d1);
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy busy=%b cfg_ready=%b required 1 0", name, busy, cfg_ready);
        end
        wait_done(500, dc);
        checks++;
        if (err !== 2'd0) begin
            errors++;
            $display("FAIL %s_err err=%0d required 0", name, err);
        end
        @(negedge clk_in0);
        checks++;
        if (done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle done=%b cfg_ready=%b busy=%b required 0 1 0", name, done, cfg_ready, busy);
        end
        checks++;
        if (exp_q.size() != 0 || rd_cnt - rd0 != 6 || wr_cnt - wr0 != 6) begin
            errors++;
            $display("FAIL %s_count reads=%0d writes=%0d left=%0d required 6 6 0",
                     name, rd_cnt - rd0, wr_cnt - wr0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_main();
        logic [15:0] w [6] = '{16'hF145, 16'hF000, 16'hF041, 16'hF000, 16'hF083, 16'hF080};
        run_normal("main", 7'd10, 7'd2, 7'd5, w);
    endtask

    task automatic test_encoding();
        logic [15:0] w [6] = '{16'hF145, 16'hF000, 16'hF001, 16'hF0C0, 16'hF000, 16'hF000};
        run_normal("enc_1_64", 7'd10, 7'd1, 7'd64, w);
    endtask

    task automatic test_illegal(input string name, input logic [6:0] m, input logic [6:0] d0, input logic [6:0] d1);
        int den0 = den_cnt;
        send(m, d0, d1);
        checks++;
        if (done !== 1'b1 || err !== 2'd1 || pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL %s_done done=%b err=%0d pll_rst=%b required 1 1 0", name, done, err, pll_rst);
        end
        repeat (4) @(negedge clk_in0);
        checks++;
        if (den_cnt != den0 || pll_rst !== 1'b0 || done !== 1'b0 || err !== 2'd1) begin
            errors++;
            $display("FAIL %s_quiet den_pulses=%0d pll_rst=%b done=%b err=%0d required 0 0 0 1",
                     name, den_cnt - den0, pll_rst, done, err);
        end
    endtask

    task automatic test_drdy_timeout();
        int fall, dc;
        withhold_at = den_cnt + 3;
        push_pair(7'h0C, 16'hF145);
        exp_q.push_back('{addr: 7'h0D, we: 1'b0, data: 16'h0000});
        send(7'd10, 7'd2, 7'd5);
        wait_rst_fall(fall);
        checks++;
        if (fall - last_den_cyc < 64 || fall - last_den_cyc > 66) begin
            errors++;
            $display("FAIL drdy_tmo_delay cycles=%0d required 64..66", fall - last_den_cyc);
        end
        wait_done(200, dc);
        checks++;
        if (err !== 2'd2) begin
            errors++;
            $display("FAIL drdy_tmo_err err=%0d required 2", err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drdy_tmo_left left=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        withhold_at = -1;
        @(negedge clk_in0);
    endtask

    task automatic test_lock_timeout();
        int fall, dc;
        logic [15:0] w [6] = '{16'hF145, 16'hF000, 16'hF041, 16'hF000, 16'hF083, 16'hF080};
        logic [6:0] addrs [6] = '{7'h0C, 7'h0D, 7'h08, 7'h09, 7'h0A, 7'h0B};
        lock_en = 1'b0;
        for (int i = 0; i < 6; i++) push_pair(addrs[i], w[i]);
        send(7'd10, 7'd2, 7'd5);
        wait_rst_fall(fall);
        wait_done(300, dc);
        checks++;
        if (dc - fall != 100 || err !== 2'd3) begin
            errors++;
            $display("FAIL lock_tmo delay=%0d err=%0d required 100 3", dc - fall, err);
        end
        lock_en = 1'b1;
        @(negedge clk_in0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [15:0] w [6] = '{16'hF145, 16'hF000, 16'hF041, 16'hF000, 16'hF083, 16'hF080};
        push_pair(7'h0C, 16'hF145);
        send(7'd10, 7'd2, 7'd5);
        while (!(den === 1'b1 && dwe === 1'b1) && n < 50) begin @(negedge clk_in0); n++; end
        @(negedge clk_in0);
        reset = 1'b1;
        @(negedge clk_in0);
        checks++;
        if (den !== 1'b0 || busy !== 1'b0 || pll_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_abort den=%b busy=%b pll_rst=%b required 0 0 1", den, busy, pll_rst);
        end
        repeat (2) @(negedge clk_in0);
        reset = 1'b0;
        @(negedge clk_in0);
        checks++;
        if (cfg_ready !== 1'b1 || pll_rst !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_exit cfg_ready=%b pll_rst=%b left=%0d required 1 0 0",
                     cfg_ready, pll_rst, exp_q.size());
            exp_q.delete();
        end
        run_normal("after_rst", 7'd10, 7'd2, 7'd5, w);
    endtask

    initial begin
        test_reset();
        test_main();
        test_encoding();
        test_illegal("div0_zero", 7'd10, 7'd0, 7'd5);
        test_illegal("mult_65", 7'd65, 7'd2, 7'd5);
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
